// File: rtl/nx_node_decoder.sv
// Inbound message decoder for a mesh node.
// Locally addressed messages become single-cycle strobes (instruction load,
// I/O mapping, signal state). Messages for other nodes and all broadcasts go
// out on a one-deep bypass stream toward their target.
module nx_node_decoder #(
  parameter int STREAM_WIDTH   = 32,
  parameter int ADDR_ROW_WIDTH = 4,
  parameter int ADDR_COL_WIDTH = 4,
  parameter int COMMAND_WIDTH  = 2,
  parameter int INPUTS         = 8,
  parameter int OUTPUTS        = 8,
  localparam int IOW = $clog2((INPUTS > OUTPUTS) ? INPUTS : OUTPUTS),
  localparam int OIW = $clog2(OUTPUTS),
  localparam int PW  = STREAM_WIDTH - 1 - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
  input  logic [ADDR_COL_WIDTH-1:0] node_col_i,
  input  logic [STREAM_WIDTH-1:0]   in_data_i,
  input  logic [1:0]                in_dir_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [STREAM_WIDTH-1:0]   byp_data_o,
  output logic [1:0]                byp_dir_o,
  output logic                      byp_valid_o,
  input  logic                      byp_ready_i,
  output logic [PW-1:0]             instr_data_o,
  output logic                      instr_valid_o,
  output logic [IOW-1:0]            map_io_o,
  output logic                      map_input_o,
  output logic [ADDR_ROW_WIDTH-1:0] map_remote_row_o,
  output logic [ADDR_COL_WIDTH-1:0] map_remote_col_o,
  output logic [OIW-1:0]            map_remote_idx_o,
  output logic                      map_slot_o,
  output logic                      map_broadcast_o,
  output logic                      map_seq_o,
  output logic                      map_valid_o,
  output logic [ADDR_ROW_WIDTH-1:0] signal_remote_row_o,
  output logic [ADDR_COL_WIDTH-1:0] signal_remote_col_o,
  output logic [OIW-1:0]            signal_remote_idx_o,
  output logic                      signal_state_o,
  output logic                      signal_valid_o,
  output logic [7:0]                err_count_o
);

  localparam logic [COMMAND_WIDTH-1:0] CMD_LOAD_INSTR = COMMAND_WIDTH'(0);
  localparam logic [COMMAND_WIDTH-1:0] CMD_CONFIGURE  = COMMAND_WIDTH'(1);
  localparam logic [COMMAND_WIDTH-1:0] CMD_SIG_STATE  = COMMAND_WIDTH'(2);

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // Payload field positions, packed upward from bit 0.
  localparam int CFG_IDX = 3;
  localparam int CFG_COL = CFG_IDX + OIW;
  localparam int CFG_ROW = CFG_COL + ADDR_COL_WIDTH;
  localparam int CFG_INP = CFG_ROW + ADDR_ROW_WIDTH;
  localparam int CFG_IO  = CFG_INP + 1;
  localparam int SIG_IDX = 1;
  localparam int SIG_COL = SIG_IDX + OIW;
  localparam int SIG_ROW = SIG_COL + ADDR_COL_WIDTH;

  logic                      hdr_bc;
  logic [ADDR_ROW_WIDTH-1:0] hdr_row;
  logic [ADDR_COL_WIDTH-1:0] hdr_col;
  logic [COMMAND_WIDTH-1:0]  hdr_cmd;
  logic [PW-1:0]             payload;
  logic                      accept;
  logic                      is_local;
  logic [1:0]                fwd_dir;

  logic [STREAM_WIDTH-1:0]   byp_data_q, byp_data_d;
  logic [1:0]                byp_dir_q, byp_dir_d;
  logic                      byp_valid_q, byp_valid_d;
  logic [PW-1:0]             instr_data_q, instr_data_d;
  logic                      instr_valid_q, instr_valid_d;
  logic [IOW-1:0]            map_io_q, map_io_d;
  logic                      map_input_q, map_input_d;
  logic [ADDR_ROW_WIDTH-1:0] map_row_q, map_row_d;
  logic [ADDR_COL_WIDTH-1:0] map_col_q, map_col_d;
  logic [OIW-1:0]            map_idx_q, map_idx_d;
  logic                      map_slot_q, map_slot_d;
  logic                      map_bc_q, map_bc_d;
  logic                      map_seq_q, map_seq_d;
  logic                      map_valid_q, map_valid_d;
  logic [ADDR_ROW_WIDTH-1:0] sig_row_q, sig_row_d;
  logic [ADDR_COL_WIDTH-1:0] sig_col_q, sig_col_d;
  logic [OIW-1:0]            sig_idx_q, sig_idx_d;
  logic                      sig_state_q, sig_state_d;
  logic                      sig_valid_q, sig_valid_d;
  logic [7:0]                err_count_q, err_count_d;

  assign hdr_bc  = in_data_i[STREAM_WIDTH-1];
  assign hdr_row = in_data_i[STREAM_WIDTH-2 -: ADDR_ROW_WIDTH];
  assign hdr_col = in_data_i[STREAM_WIDTH-2-ADDR_ROW_WIDTH -: ADDR_COL_WIDTH];
  assign hdr_cmd = in_data_i[STREAM_WIDTH-2-ADDR_ROW_WIDTH-ADDR_COL_WIDTH -: COMMAND_WIDTH];
  assign payload = in_data_i[PW-1:0];

  // The bypass register can take a new message whenever it is empty or draining now.
  assign in_ready_o = !byp_valid_q || byp_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign is_local   = hdr_bc || (hdr_row == node_row_i && hdr_col == node_col_i);

  // Route: broadcasts keep travelling away from where they came in; others go row first, then column.
  always_comb begin
    fwd_dir = DIR_E;
    if (hdr_bc)                  fwd_dir = in_dir_i ^ 2'b10;
    else if (hdr_row < node_row_i) fwd_dir = DIR_N;
    else if (hdr_row > node_row_i) fwd_dir = DIR_S;
    else if (hdr_col < node_col_i) fwd_dir = DIR_W;
  end

  // Next state for the bypass register, the decode strobes and fields, and the error counter.
  always_comb begin
    byp_data_d    = byp_data_q;
    byp_dir_d     = byp_dir_q;
    byp_valid_d   = byp_valid_q;
    instr_data_d  = instr_data_q;
    instr_valid_d = 1'b0;
    map_io_d      = map_io_q;
    map_input_d   = map_input_q;
    map_row_d     = map_row_q;
    map_col_d     = map_col_q;
    map_idx_d     = map_idx_q;
    map_slot_d    = map_slot_q;
    map_bc_d      = map_bc_q;
    map_seq_d     = map_seq_q;
    map_valid_d   = 1'b0;
    sig_row_d     = sig_row_q;
    sig_col_d     = sig_col_q;
    sig_idx_d     = sig_idx_q;
    sig_state_d   = sig_state_q;
    sig_valid_d   = 1'b0;
    err_count_d   = err_count_q;

    if (accept && (hdr_bc || !is_local)) begin
      byp_data_d  = in_data_i;
      byp_dir_d   = fwd_dir;
      byp_valid_d = 1'b1;
    end else if (byp_ready_i) begin
      byp_valid_d = 1'b0;
    end

    if (accept && is_local) begin
      case (hdr_cmd)
        CMD_LOAD_INSTR: begin
          instr_data_d  = payload;
          instr_valid_d = 1'b1;
        end
        CMD_CONFIGURE: begin
          map_io_d    = payload[CFG_IO +: IOW];
          map_input_d = payload[CFG_INP];
          map_row_d   = payload[CFG_ROW +: ADDR_ROW_WIDTH];
          map_col_d   = payload[CFG_COL +: ADDR_COL_WIDTH];
          map_idx_d   = payload[CFG_IDX +: OIW];
          map_slot_d  = payload[2];
          map_bc_d    = payload[1];
          map_seq_d   = payload[0];
          map_valid_d = 1'b1;
        end
        CMD_SIG_STATE: begin
          sig_row_d   = payload[SIG_ROW +: ADDR_ROW_WIDTH];
          sig_col_d   = payload[SIG_COL +: ADDR_COL_WIDTH];
          sig_idx_d   = payload[SIG_IDX +: OIW];
          sig_state_d = payload[0];
          sig_valid_d = 1'b1;
        end
        default: begin
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
      endcase
    end
  end

  // State registers; reset clears everything, including a stalled bypass message.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byp_data_q    <= '0;
      byp_dir_q     <= '0;
      byp_valid_q   <= 1'b0;
      instr_data_q  <= '0;
      instr_valid_q <= 1'b0;
      map_io_q      <= '0;
      map_input_q   <= 1'b0;
      map_row_q     <= '0;
      map_col_q     <= '0;
      map_idx_q     <= '0;
      map_slot_q    <= 1'b0;
      map_bc_q      <= 1'b0;
      map_seq_q     <= 1'b0;
      map_valid_q   <= 1'b0;
      sig_row_q     <= '0;
      sig_col_q     <= '0;
      sig_idx_q     <= '0;
      sig_state_q   <= 1'b0;
      sig_valid_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      byp_data_q    <= byp_data_d;
      byp_dir_q     <= byp_dir_d;
      byp_valid_q   <= byp_valid_d;
      instr_data_q  <= instr_data_d;
      instr_valid_q <= instr_valid_d;
      map_io_q      <= map_io_d;
      map_input_q   <= map_input_d;
      map_row_q     <= map_row_d;
      map_col_q     <= map_col_d;
      map_idx_q     <= map_idx_d;
      map_slot_q    <= map_slot_d;
      map_bc_q      <= map_bc_d;
      map_seq_q     <= map_seq_d;
      map_valid_q   <= map_valid_d;
      sig_row_q     <= sig_row_d;
      sig_col_q     <= sig_col_d;
      sig_idx_q     <= sig_idx_d;
      sig_state_q   <= sig_state_d;
      sig_valid_q   <= sig_valid_d;
      err_count_q   <= err_count_d;
    end
  end

  assign byp_data_o          = byp_data_q;
  assign byp_dir_o           = byp_dir_q;
  assign byp_valid_o         = byp_valid_q;
  assign instr_data_o        = instr_data_q;
  assign instr_valid_o       = instr_valid_q;
  assign map_io_o            = map_io_q;
  assign map_input_o         = map_input_q;
  assign map_remote_row_o    = map_row_q;
  assign map_remote_col_o    = map_col_q;
  assign map_remote_idx_o    = map_idx_q;
  assign map_slot_o          = map_slot_q;
  assign map_broadcast_o     = map_bc_q;
  assign map_seq_o           = map_seq_q;
  assign map_valid_o         = map_valid_q;
  assign signal_remote_row_o = sig_row_q;
  assign signal_remote_col_o = sig_col_q;
  assign signal_remote_idx_o = sig_idx_q;
  assign signal_state_o      = sig_state_q;
  assign signal_valid_o      = sig_valid_q;
  assign err_count_o         = err_count_q;

endmodule

// File: tb/tb_nx_node_decoder.sv
// Scoreboard bench for nx_node_decoder: each scenario task pushes the outputs
// it expects, and every clock the monitor in step() pops and compares any
// strobe or bypass transfer the DUT produces.
module tb_nx_node_decoder;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic [2:0] idx;
    logic       st;
  } sig_t;

  typedef struct packed {
    logic [2:0] io;
    logic       inp;
    logic [3:0] row;
    logic [3:0] col;
    logic [2:0] idx;
    logic       slot;
    logic       bc;
    logic       seq;
  } map_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  dir;
  } byp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  node_row = 4'd2;
  logic [3:0]  node_col = 4'd3;
  logic [31:0] in_data;
  logic [1:0]  in_dir;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] byp_data;
  logic [1:0]  byp_dir;
  logic        byp_valid;
  logic        byp_ready;
  logic [20:0] instr_data;
  logic        instr_valid;
  logic [2:0]  map_io;
  logic        map_input;
  logic [3:0]  map_row;
  logic [3:0]  map_col;
  logic [2:0]  map_idx;
  logic        map_slot;
  logic        map_bc;
  logic        map_seq;
  logic        map_valid;
  logic [3:0]  sig_row;
  logic [3:0]  sig_col;
  logic [2:0]  sig_idx;
  logic        sig_state;
  logic        sig_valid;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  logic [20:0] exp_instr[$];
  map_t        exp_map[$];
  sig_t        exp_sig[$];
  byp_t        exp_byp[$];

  always #5 clk = ~clk;

  nx_node_decoder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .node_row_i(node_row), .node_col_i(node_col),
    .in_data_i(in_data), .in_dir_i(in_dir), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .byp_data_o(byp_data), .byp_dir_o(byp_dir), .byp_valid_o(byp_valid), .byp_ready_i(byp_ready),
    .instr_data_o(instr_data), .instr_valid_o(instr_valid),
    .map_io_o(map_io), .map_input_o(map_input), .map_remote_row_o(map_row),
    .map_remote_col_o(map_col), .map_remote_idx_o(map_idx), .map_slot_o(map_slot),
    .map_broadcast_o(map_bc), .map_seq_o(map_seq), .map_valid_o(map_valid),
    .signal_remote_row_o(sig_row), .signal_remote_col_o(sig_col),
    .signal_remote_idx_o(sig_idx), .signal_state_o(sig_state), .signal_valid_o(sig_valid),
    .err_count_o(err_count)
  );

  function automatic logic [31:0] mk_msg(input logic bc, input logic [3:0] row,
                                         input logic [3:0] col, input logic [1:0] cmd,
                                         input logic [20:0] pl);
    return {bc, row, col, cmd, pl};
  endfunction

  function automatic logic [20:0] sig_pl(input sig_t s);
    return {9'd0, s};
  endfunction

  function automatic logic [20:0] cfg_pl(input map_t m);
    return {3'd0, m};
  endfunction

  // One clock: at the falling edge compare every strobe and bypass transfer against the scoreboard.
  task automatic step(output logic acc);
    byp_t a_byp;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (instr_valid) begin
      total++;
      if (exp_instr.size() == 0) begin
        bad++; $display("[TB] FAIL instr_unexpected got=%h want=none", instr_data);
      end else if (instr_data !== exp_instr[0]) begin
        bad++; $display("[TB] FAIL instr_data got=%h want=%h", instr_data, exp_instr[0]);
      end
      if (exp_instr.size() != 0) void'(exp_instr.pop_front());
    end
    if (map_valid) begin
      total++;
      if (exp_map.size() == 0) begin
        bad++; $display("[TB] FAIL map_unexpected got=%h want=none",
                        {map_io, map_input, map_row, map_col, map_idx, map_slot, map_bc, map_seq});
      end else if ({map_io, map_input, map_row, map_col, map_idx, map_slot, map_bc, map_seq} !== exp_map[0]) begin
        bad++; $display("[TB] FAIL map_fields got=%h want=%h",
                        {map_io, map_input, map_row, map_col, map_idx, map_slot, map_bc, map_seq}, exp_map[0]);
      end
      if (exp_map.size() != 0) void'(exp_map.pop_front());
    end
    if (sig_valid) begin
      total++;
      if (exp_sig.size() == 0) begin
        bad++; $display("[TB] FAIL sig_unexpected got=%h want=none", {sig_row, sig_col, sig_idx, sig_state});
      end else if ({sig_row, sig_col, sig_idx, sig_state} !== exp_sig[0]) begin
        bad++; $display("[TB] FAIL sig_fields got=%h want=%h", {sig_row, sig_col, sig_idx, sig_state}, exp_sig[0]);
      end
      if (exp_sig.size() != 0) void'(exp_sig.pop_front());
    end
    if (byp_valid && byp_ready) begin
      total++;
      a_byp = '{data: byp_data, dir: byp_dir};
      if (exp_byp.size() == 0) begin
        bad++; $display("[TB] FAIL byp_unexpected got=%h want=none", a_byp);
      end else if (a_byp !== exp_byp[0]) begin
        bad++; $display("[TB] FAIL byp_xfer got=%h want=%h", a_byp, exp_byp[0]);
      end
      if (exp_byp.size() != 0) void'(exp_byp.pop_front());
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  // Present one message and hold it until accepted, with a bounded wait.
  task automatic send(input logic [31:0] data, input logic [1:0] dir);
    logic acc;
    int   n = 0;
    in_data  = data;
    in_dir   = dir;
    in_valid = 1'b1;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 20);
    in_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++; $display("[TB] FAIL send_timeout got=not_accepted want=accepted data=%h", data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; byp_ready = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = '0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    total++;
    if ({byp_valid, instr_valid, map_valid, sig_valid} !== 4'b0) begin
      bad++; $display("[TB] FAIL reset_valids got=%b want=0000", {byp_valid, instr_valid, map_valid, sig_valid});
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", in_ready); end
    total++;
    if (err_count !== 8'd0 || byp_dir !== 2'd0 || byp_data !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_data got=%h/%h/%h want=0/0/0", err_count, byp_dir, byp_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_signal();
    logic acc;
    sig_t s = '{row: 4'd1, col: 4'd3, idx: 3'd5, st: 1'b1};
    exp_sig.push_back(s);
    send(mk_msg(1'b0, 4'd2, 4'd3, 2'd2, sig_pl(s)), 2'd0);
    total++;
    if (sig_valid !== 1'b1 || byp_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL sig_latency got=%b%b want=10", sig_valid, byp_valid);
    end
    step(acc);
    total++;
    if (sig_valid !== 1'b0) begin bad++; $display("[TB] FAIL sig_one_cycle got=%b want=0", sig_valid); end
    total++;
    if ({sig_row, sig_col, sig_idx, sig_state} !== s) begin
      bad++; $display("[TB] FAIL sig_hold got=%h want=%h", {sig_row, sig_col, sig_idx, sig_state}, s);
    end
  endtask

  task automatic test_instr();
    exp_instr.push_back(21'h1ABCDE);
    send(mk_msg(1'b0, 4'd2, 4'd3, 2'd0, 21'h1ABCDE), 2'd3);
    exp_instr.push_back(21'h000001);
    send(mk_msg(1'b0, 4'd2, 4'd3, 2'd0, 21'h000001), 2'd1);
    idle(2);
  endtask

  task automatic test_back_to_back();
    map_t m = '{io: 3'd6, inp: 1'b1, row: 4'd4, col: 4'd7, idx: 3'd2, slot: 1'b0, bc: 1'b0, seq: 1'b1};
    for (int i = 0; i < 4; i++) begin
      exp_map.push_back(m);
      send(mk_msg(1'b0, 4'd2, 4'd3, 2'd1, cfg_pl(m)), 2'd2);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready got=%b want=1", in_ready); end
      total++;
      if (i > 0 && map_valid !== 1'b1) begin
        bad++; $display("[TB] FAIL b2b_pulse got=%b want=1 at %0d", map_valid, i);
      end
    end
    idle(2);
  endtask

  task automatic test_routing();
    logic [3:0] rows[4] = '{4'd0, 4'd5, 4'd2, 4'd2};
    logic [3:0] cols[4] = '{4'd3, 4'd3, 4'd1, 4'd9};
    logic [1:0] dirs[4] = '{2'd0, 2'd2, 2'd3, 2'd1};
    logic [31:0] m;
    byp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m = mk_msg(1'b0, rows[i], cols[i], 2'd0, 21'(i + 16));
      exp_byp.push_back('{data: m, dir: dirs[i]});
      send(m, 2'd1);
    end
    idle(3);
  endtask

  task automatic test_stall();
    logic acc;
    logic [31:0] m1 = mk_msg(1'b0, 4'd0, 4'd0, 2'd1, 21'h0AAAAA);
    logic [31:0] m2 = mk_msg(1'b0, 4'd7, 4'd3, 2'd2, 21'h155555);
    byp_ready = 1'b0;
    exp_byp.push_back('{data: m1, dir: 2'd0});
    send(m1, 2'd2);
    exp_byp.push_back('{data: m2, dir: 2'd2});
    in_data = m2; in_dir = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(acc);
      total++;
      if (acc !== 1'b0 || in_ready !== 1'b0) begin
        bad++; $display("[TB] FAIL stall_ready got=%b want=0 cycle %0d", in_ready, i);
      end
      total++;
      if (byp_data !== m1 || byp_valid !== 1'b1) begin
        bad++; $display("[TB] FAIL stall_hold got=%h want=%h", byp_data, m1);
      end
    end
    byp_ready = 1'b1;
    step(acc);
    in_valid = 1'b0;
    total++;
    if (acc !== 1'b1) begin bad++; $display("[TB] FAIL stall_release got=%b want=1", acc); end
    idle(3);
  endtask

  task automatic test_broadcast();
    sig_t s = '{row: 4'd4, col: 4'd1, idx: 3'd2, st: 1'b0};
    logic [31:0] m = mk_msg(1'b1, 4'd7, 4'd7, 2'd2, sig_pl(s));
    byp_ready = 1'b1;
    exp_sig.push_back(s);
    exp_byp.push_back('{data: m, dir: 2'd3});
    send(m, 2'd1);
    total++;
    if (sig_valid !== 1'b1 || byp_valid !== 1'b1 || byp_dir !== 2'd3) begin
      bad++; $display("[TB] FAIL bcast_both got=%b%b dir=%0d want=11 dir=3", sig_valid, byp_valid, byp_dir);
    end
    idle(2);
  endtask

  task automatic test_reserved();
    logic [31:0] m;
    byp_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      m = mk_msg(i == 259, 4'd2, 4'd3, 2'd3, 21'(i));
      if (i == 259) exp_byp.push_back('{data: m, dir: 2'd2});
      send(m, 2'd0);
      if (i == 9) begin
        total++;
        if (err_count !== 8'd10) begin bad++; $display("[TB] FAIL err_count_10 got=%0d want=10", err_count); end
      end
    end
    idle(2);
    total++;
    if (err_count !== 8'd255) begin bad++; $display("[TB] FAIL err_saturate got=%0d want=255", err_count); end
  endtask

  task automatic test_reset_mid_stall();
    byp_ready = 1'b0;
    send(mk_msg(1'b0, 4'd9, 4'd9, 2'd0, 21'h12345), 2'd0);
    total++;
    if (byp_valid !== 1'b1) begin bad++; $display("[TB] FAIL midrst_setup got=%b want=1", byp_valid); end
    rst_n = 1'b0;
    #1;
    total++;
    if (byp_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL midrst_clear got=%b%b want=01", byp_valid, in_ready);
    end
    total++;
    if (err_count !== 8'd0 || sig_row !== 4'd0) begin
      bad++; $display("[TB] FAIL midrst_data got=%0d/%0d want=0/0", err_count, sig_row);
    end
    idle(1);
    rst_n = 1'b1;
    byp_ready = 1'b1;
    idle(3);
    total++;
    if (in_ready !== 1'b1 || byp_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_after got=%b%b want=10", in_ready, byp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_signal();
    test_instr();
    test_back_to_back();
    test_routing();
    test_stall();
    test_broadcast();
    test_reserved();
    test_reset_mid_stall();
    total++;
    if (exp_instr.size() + exp_map.size() + exp_sig.size() + exp_byp.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain got=%0d/%0d/%0d/%0d want=0/0/0/0",
               exp_instr.size(), exp_map.size(), exp_sig.size(), exp_byp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
